// File: rtl/serial_cmp8_pkg.sv
// Shared types and helpers for the MSB-first bit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;

  // Width of a counter that must be able to hold the value w.
  function automatic int CMP_CNT_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_cmp8_if.sv
// Request/result bundle of serial_cmp8; master is the requester, slave is the comparator.
interface serial_cmp8_if import cmp_pkg::*; #(
  parameter int WIDTH = 8
);

  logic                          start;
  logic                          ready;
  logic [0:WIDTH-1]              a;
  logic [0:WIDTH-1]              b;
  logic                          eq_in;
  logic                          gt_in;
  logic                          done;
  logic                          EQ;
  logic                          GT;
  logic [CMP_CNT_W(WIDTH)-1:0]   bits_seen;

  modport master (
    output start, a, b, eq_in, gt_in,
    input  ready, done, EQ, GT, bits_seen
  );

  modport slave (
    input  start, a, b, eq_in, gt_in,
    output ready, done, EQ, GT, bits_seen
  );

endinterface

// File: rtl/serial_cmp8_msb_bit_cell.sv
// Single-bit compare cell: reports whether the two bits differ and whether a wins.
module msb_bit_cell (
  input  logic a,
  input  logic b,
  output logic dec,
  output logic gt
);

  assign dec = a ^ b;
  assign gt  = a & ~b;

endmodule

// File: rtl/serial_cmp8.sv
// MSB-first bit-serial magnitude comparator with cmp8-compatible cascade inputs.
module serial_cmp8 import cmp_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_cmp8_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = CMP_CNT_W(WIDTH);

  cmp_state_t        state;
  logic [0:WIDTH-1]  a_r;
  logic [0:WIDTH-1]  b_r;
  logic              eq_in_r;
  logic              gt_in_r;
  logic              dec_r;
  logic              res_gt_r;
  logic [IDX_W-1:0]  idx;
  logic              cell_dec;
  logic              cell_gt;
  logic              last_bit;
  logic              finish;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(WIDTH)) ? v : v + CNT_W'(1);
  endfunction

  msb_bit_cell u_cell (
    .a   (a_r[idx]),
    .b   (b_r[idx]),
    .dec (cell_dec),
    .gt  (cell_gt)
  );

  assign last_bit = (idx == IDX_W'(WIDTH - 1));
  // Constant-latency mode ignores the decision and always runs to the last bit.
  assign finish   = (EARLY_EXIT != 0) ? (cell_dec || last_bit) : last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_r           <= '0;
      b_r           <= '0;
      eq_in_r       <= 1'b0;
      gt_in_r       <= 1'b0;
      dec_r         <= 1'b0;
      res_gt_r      <= 1'b0;
      idx           <= '0;
      bus.ready     <= 1'b1;
      bus.done      <= 1'b0;
      bus.EQ        <= 1'b0;
      bus.GT        <= 1'b0;
      bus.bits_seen <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r           <= bus.a;
            b_r           <= bus.b;
            eq_in_r       <= bus.eq_in;
            gt_in_r       <= bus.gt_in;
            dec_r         <= 1'b0;
            res_gt_r      <= 1'b0;
            idx           <= '0;
            bus.bits_seen <= '0;
            bus.EQ        <= 1'b0;
            bus.GT        <= 1'b0;
            bus.ready     <= 1'b0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          bus.bits_seen <= sat_inc(bus.bits_seen);
          if (!dec_r && cell_dec) begin
            dec_r    <= 1'b1;
            res_gt_r <= cell_gt;
          end
          if (finish) begin
            // The first differing bit wins; the cascade pair only matters when all bits tie.
            if (dec_r) begin
              bus.EQ <= 1'b0;
              bus.GT <= res_gt_r;
            end else if (cell_dec) begin
              bus.EQ <= 1'b0;
              bus.GT <= cell_gt;
            end else begin
              bus.EQ <= eq_in_r;
              bus.GT <= gt_in_r;
            end
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
